// File: rtl/dffram_pkg.sv
// Shared types and helpers for the 1W/1R DFF RAM: clear-FSM state encoding,
// byte parity and the byte-masked merge used by both writes and forwarding.
package dffram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int MAX_DW = 1024;
    localparam int MAX_NB = MAX_DW / 8;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // Callers zero-extend into the widest supported word and truncate the result.
    function automatic logic [MAX_DW-1:0] merge_lanes(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_NB-1:0] we
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_NB; i++) begin
            if (we[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dffram_clr_fsm.sv
// Post-reset zero-fill sequencer: sweeps every address once, then parks in READY.
module dffram_clr_fsm
    import dffram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_cnt_nxt;

    // State and sweep-counter registers; reset restarts the sweep at address 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= {AW{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_cnt_nxt;
        end
    end

    // Next-state: advance through the array, leave CLEAR once the last word is written.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = {AW{1'b0}};
                end else begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = r_clr_cnt + AW'(1'b1);
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
                w_cnt_nxt   = {AW{1'b0}};
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = {AW{1'b0}};
            end
        endcase
    end

    assign o_busy     = (r_state == ST_CLEAR);
    // Memory is left untouched in the reset cycle itself.
    assign o_clr_we   = o_busy && !i_rst;
    assign o_clr_addr = r_clr_cnt;

endmodule

// File: rtl/dffram_1r1w_beh.sv
// Two-port (1W/1R) behavioural DFF RAM with zero-fill after reset and write-first forwarding.
// Optional per-byte even parity with error injection: define DFFRAM_PARITY_EN.
module dffram_1r1w_beh
    import dffram_pkg::*;
#(
    parameter  int WSIZE = 4,
    parameter  int DW    = 32,
    localparam int DEPTH = 256 * WSIZE,
    localparam int NB    = DW / 8,
    localparam int AW    = 8 + $clog2(WSIZE)
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          BUSY,
    input  logic          EN0,
    input  logic [NB-1:0] WE0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] Di0,
    input  logic          EN1,
    input  logic [AW-1:0] A1,
    output logic [DW-1:0] Do1,
`ifdef DFFRAM_PARITY_EN
    output logic          VLD1,
    input  logic          PINJ0,
    output logic          PERR1
`else
    output logic          VLD1
`endif
);

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_collide;
    logic [DW-1:0] w_wr_word;
    logic [DW-1:0] w_rd_word;

    dffram_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .i_clk      (CLK),
        .i_rst      (RST),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign BUSY      = w_busy;
    assign w_collide = EN0 && EN1 && (A0 == A1);
    assign w_wr_word = DW'(merge_lanes(MAX_DW'(r_mem[A0]), MAX_DW'(Di0), MAX_NB'(WE0)));
    // Write-first: written lanes come from Di0, the rest from the array.
    assign w_rd_word = w_collide
                     ? DW'(merge_lanes(MAX_DW'(r_mem[A1]), MAX_DW'(Di0), MAX_NB'(WE0)))
                     : r_mem[A1];

`ifdef DFFRAM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_par_wr;
    logic          w_perr;

    // Parity of written lanes (optionally inverted) and the read-side lane check.
    always_comb begin
        w_par_wr = r_par[A0];
        w_perr   = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (WE0[i]) begin
                w_par_wr[i] = byte_parity(Di0[8*i +: 8]) ^ PINJ0;
            end else begin
                w_par_wr[i] = r_par[A0][i];
            end
            if (w_collide && WE0[i]) begin
                w_perr = w_perr;
            end else begin
                w_perr = w_perr | (byte_parity(r_mem[A1][8*i +: 8]) ^ r_par[A1][i]);
            end
        end
    end
`endif

    // Array update: zero-fill during the sweep, byte-masked writes once ready.
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= {DW{1'b0}};
`ifdef DFFRAM_PARITY_EN
            r_par[w_clr_addr] <= {NB{1'b0}};
`endif
        end else if (!RST && !w_busy && EN0) begin
            r_mem[A0] <= w_wr_word;
`ifdef DFFRAM_PARITY_EN
            r_par[A0] <= w_par_wr;
`endif
        end
    end

    // Registered read port; quiet (zero, not valid) during reset and the sweep.
    always_ff @(posedge CLK) begin
        if (RST || w_busy || !EN1) begin
            Do1   <= {DW{1'b0}};
            VLD1  <= 1'b0;
`ifdef DFFRAM_PARITY_EN
            PERR1 <= 1'b0;
`endif
        end else begin
            Do1   <= w_rd_word;
            VLD1  <= 1'b1;
`ifdef DFFRAM_PARITY_EN
            PERR1 <= w_perr;
`endif
        end
    end

endmodule
